// File: rtl/draw_pkg.sv
// Shared constants, state encoding and packed-field helpers for the draw arbiter.
package draw_pkg;

    localparam int XW_DEF       = 9;
    localparam int YW_DEF       = 8;
    localparam int CW_DEF       = 12;
    localparam int SCREEN_W_DEF = 320;

    localparam int CH_P0 = 0;
    localparam int CH_P1 = 1;
    localparam int CH_P2 = 2;
    localparam int CH_P3 = 3;
    localparam int CH_DP = 4;

    localparam logic [11:0] COL_P0 = 12'hF00;
    localparam logic [11:0] COL_P1 = 12'h0F0;
    localparam logic [11:0] COL_P2 = 12'h00F;
    localparam logic [11:0] COL_P3 = 12'hFF0;
    localparam logic [11:0] COL_DP = 12'hFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Lowest bit of channel ch's field in a bus packed with w bits per channel.
    function automatic int field_lo(input int ch, input int w);
        return ch * w;
    endfunction

    function automatic int field_hi(input int ch, input int w);
        return ch * w + w - 1;
    endfunction

endpackage

// File: rtl/draw_arbiter_n_rr_pick.sv
// Combinational picker: first set request at or after ptr_i, searching upward with wrap.
module rr_pick
    import draw_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] idx;

    // Two passes: indices at/after the pointer first, then the wrapped-around low indices.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

    assign found_o = found;
    assign idx_o   = idx;

endmodule

// File: rtl/draw_arbiter_n.sv
// N-channel pixel-draw arbiter with burst locking and a single registered output slot.
// Optional DRAW_ARB_BGADDR_EN adds a registered background address output (y*SCREEN_W + x).
module draw_arbiter_n
    import draw_pkg::*;
#(
    parameter int NCH      = 5,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF,
    parameter int CW       = CW_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int RR_MODE  = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NCH-1:0]            req_valid,
    input  logic [NCH-1:0]            req_last,
    input  logic [NCH*XW-1:0]         req_x,
    input  logic [NCH*YW-1:0]         req_y,
    input  logic [NCH*CW-1:0]         req_c,
    output logic [NCH-1:0]            req_ready,
    input  logic                      out_ready,
    output logic                      plot,
    output logic [XW-1:0]             x,
    output logic [YW-1:0]             y,
    output logic [CW-1:0]             c,
    output logic [$clog2(NCH)-1:0]    grant_id,
`ifdef DRAW_ARB_BGADDR_EN
    output logic [$clog2(SCREEN_W*(2**YW))-1:0] bg_addr,
`endif
    output logic                      busy
);

    localparam int IW = $clog2(NCH);

    arb_state_e    state_q;
    logic [IW-1:0] lock_q, ptr_q, grant_q;
    logic          started_q, plot_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] c_q;

    logic          slot_free, pick_found, accept, sel_last;
    logic [IW-1:0] pick_idx, sel, ptr_eff, ptr_d;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [CW-1:0] sel_c;

    assign ptr_eff = (RR_MODE != 0) ? ptr_q : '0;

    rr_pick #(.N(NCH), .IW(IW)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_eff),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Handshake: a beat transfers on channel i when req_valid[i] && req_ready[i]; at most one
    // req_ready bit is high, and only while the output slot is empty or being drained this cycle.
    always_comb begin
        slot_free = !plot_q || out_ready;
        sel       = (state_q == ST_LOCK) ? lock_q : pick_idx;
        req_ready = '0;
        if (started_q && slot_free) begin
            if (state_q == ST_LOCK) begin
                req_ready[lock_q] = 1'b1;
            end else if (pick_found) begin
                req_ready[pick_idx] = 1'b1;
            end
        end
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == IW'(i)) begin
                sel_x = req_x[field_lo(i, XW) +: XW];
                sel_y = req_y[field_lo(i, YW) +: YW];
                sel_c = req_c[field_lo(i, CW) +: CW];
            end
        end
        accept   = |(req_valid & req_ready);
        sel_last = |(req_last & req_ready);
    end

    assign ptr_d = (sel == IW'(NCH - 1)) ? '0 : sel + 1'b1;

`ifdef DRAW_ARB_BGADDR_EN
    localparam int BW = $clog2(SCREEN_W*(2**YW));
    logic [BW-1:0] bg_q, bg_d;
    assign bg_d    = BW'(sel_y) * BW'(SCREEN_W) + BW'(sel_x);
    assign bg_addr = bg_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            lock_q    <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            started_q <= 1'b0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            c_q       <= '0;
`ifdef DRAW_ARB_BGADDR_EN
            bg_q      <= '0;
`endif
        end else begin
            started_q <= 1'b1;
            if (accept) begin
                plot_q  <= 1'b1;
                x_q     <= sel_x;
                y_q     <= sel_y;
                c_q     <= sel_c;
                grant_q <= sel;
`ifdef DRAW_ARB_BGADDR_EN
                bg_q    <= bg_d;
`endif
                if (sel_last) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= ptr_d;
                end else begin
                    state_q <= ST_LOCK;
                    lock_q  <= sel;
                end
            end else if (out_ready) begin
                plot_q <= 1'b0;
            end
        end
    end

    assign plot     = plot_q;
    assign x        = x_q;
    assign y        = y_q;
    assign c        = c_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_draw_arbiter_n.sv
// Directed bench for draw_arbiter_n: reset, round-robin, burst lock, back-pressure, bubbles, fixed priority.
module tb_draw_arbiter_n;
    import draw_pkg::*;

    localparam int NCH = 5;
    localparam int XW  = 9;
    localparam int YW  = 8;
    localparam int CW  = 12;
    localparam int BW  = $clog2(320*(2**YW));

    logic              clk;
    logic              resetn;
    logic [NCH-1:0]    req_valid, req_last;
    logic [NCH*XW-1:0] req_x;
    logic [NCH*YW-1:0] req_y;
    logic [NCH*CW-1:0] req_c;
    logic              out_ready;

    logic [NCH-1:0] req_ready, f_ready;
    logic           plot, busy, f_plot, f_busy;
    logic [XW-1:0]  x, f_x;
    logic [YW-1:0]  y, f_y;
    logic [CW-1:0]  c, f_c;
    logic [2:0]     grant_id, f_grant;
    logic [BW-1:0]  bg_addr, f_bg;

    int n_checks = 0;
    int n_errors = 0;

    draw_arbiter_n #(.NCH(NCH), .RR_MODE(1)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_c(req_c), .req_ready(req_ready),
        .out_ready(out_ready), .plot(plot), .x(x), .y(y), .c(c), .grant_id(grant_id),
`ifdef DRAW_ARB_BGADDR_EN
        .bg_addr(bg_addr),
`endif
        .busy(busy)
    );

    draw_arbiter_n #(.NCH(NCH), .RR_MODE(0)) u_fix (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_c(req_c), .req_ready(f_ready),
        .out_ready(out_ready), .plot(f_plot), .x(f_x), .y(f_y), .c(f_c), .grant_id(f_grant),
`ifdef DRAW_ARB_BGADDR_EN
        .bg_addr(f_bg),
`endif
        .busy(f_busy)
    );

`ifndef DRAW_ARB_BGADDR_EN
    assign bg_addr = '0;
    assign f_bg    = '0;
`endif

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic l,
                          input int xv, input int yv, input int cv);
        req_valid[ch]          = v;
        req_last[ch]           = l;
        req_x[ch*XW +: XW]     = XW'(xv);
        req_y[ch*YW +: YW]     = YW'(yv);
        req_c[ch*CW +: CW]     = CW'(cv);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b1;
        req_valid = NCH'($urandom_range(0, 31));
        req_last  = NCH'($urandom_range(0, 31));
        req_x     = {$urandom, $urandom};
        req_y     = {$urandom, $urandom};
        req_c     = {$urandom, $urandom};

        // Reset with random requests
        repeat (3) tick();
        check("rst_plot", 32'(plot), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_x", 32'(x), 0);

        // Round-robin, all channels single-beat
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b1, i*10 + 1, i*2 + 3, 32'h100 * i + 5);
        resetn = 1'b1;
        #1;
        check("rdy_before_edge", 32'(req_ready), 0);
        tick();
        check("no_accept_edge1", 32'(plot), 0);
        check("rdy_after_edge1", 32'(req_ready), 32'b00001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_plot", 32'(plot), 1);
            check("rr_grant", 32'(grant_id), k % 5);
            check("rr_x", 32'(x), (k % 5)*10 + 1);
            check("rr_y", 32'(y), (k % 5)*2 + 3);
            check("rr_c", 32'(c), 32'h100*(k % 5) + 5);
        end

        // Burst lock on ch2 while ch0 keeps requesting
        clear_all();
        set_ch(0, 1'b1, 1'b1, 100, 5, 32'h0F0);
        for (int b = 0; b < 4; b++) begin
            set_ch(2, 1'b1, (b == 3), 10 + b, 20, 32'hABC);
            #1;
            if (b == 1) check("lock_ready", 32'(req_ready), 32'b00100);
            tick();
            check("lock_x", 32'(x), 10 + b);
            check("lock_grant", 32'(grant_id), 2);
            check("lock_busy", 32'(busy), (b < 3) ? 1 : 0);
        end
        set_ch(2, 1'b0, 1'b0, 0, 0, 0);
        tick();
        check("after_lock_grant", 32'(grant_id), 0);
        check("after_lock_x", 32'(x), 100);
        check("after_lock_busy", 32'(busy), 0);

        // Back-pressure mid-burst on ch4
        set_ch(0, 1'b0, 1'b0, 0, 0, 0);
        set_ch(4, 1'b1, 1'b0, 200, 40, 32'h123);
        tick();
        check("bp_x0", 32'(x), 200);
        set_ch(4, 1'b1, 1'b0, 201, 40, 32'h123);
        tick();
        check("bp_x1", 32'(x), 201);
        set_ch(4, 1'b1, 1'b0, 202, 41, 32'h124);
        out_ready = 1'b0;
        #1;
        check("bp_ready", 32'(req_ready), 0);
        for (int h = 0; h < 3; h++) begin
            tick();
            check("bp_hold_x", 32'(x), 201);
            check("bp_hold_y", 32'(y), 40);
            check("bp_hold_plot", 32'(plot), 1);
            check("bp_hold_busy", 32'(busy), 1);
            check("bp_hold_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_resume_x", 32'(x), 202);
        check("bp_resume_c", 32'(c), 32'h124);
        set_ch(4, 1'b1, 1'b1, 203, 42, 32'h125);
        tick();
        check("bp_last_x", 32'(x), 203);
        check("bp_last_busy", 32'(busy), 0);
        set_ch(4, 1'b0, 1'b0, 0, 0, 0);
        tick();
        check("drain_plot", 32'(plot), 0);
        check("drain_grant", 32'(grant_id), 4);

        // Locked channel goes idle: bubble, other channel ignored
        set_ch(1, 1'b1, 1'b0, 50, 7, 32'h050);
        tick();
        check("bub_x0", 32'(x), 50);
        check("bub_busy0", 32'(busy), 1);
        set_ch(1, 1'b0, 1'b0, 50, 7, 32'h050);
        set_ch(3, 1'b1, 1'b1, 70, 9, 32'h070);
        #1;
        check("bub_ready", 32'(req_ready), 32'b00010);
        tick();
        check("bub_plot", 32'(plot), 0);
        check("bub_busy", 32'(busy), 1);
        set_ch(1, 1'b1, 1'b1, 51, 7, 32'h051);
        tick();
        check("bub_x1", 32'(x), 51);
        check("bub_grant", 32'(grant_id), 1);
        check("bub_busy1", 32'(busy), 0);

        // Reset mid-burst
        set_ch(1, 1'b0, 1'b0, 0, 0, 0);
        set_ch(3, 1'b1, 1'b0, 70, 9, 32'h070);
        tick();
        check("mid_busy_pre", 32'(busy), 1);
        check("mid_x_pre", 32'(x), 70);
        resetn = 1'b0;
        #1;
        check("mid_rst_plot", 32'(plot), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_x", 32'(x), 0);
        check("mid_rst_grant", 32'(grant_id), 0);
        check("mid_rst_ready", 32'(req_ready), 0);

        // Fixed priority vs round-robin with ch1 and ch3 requesting
        clear_all();
        set_ch(1, 1'b1, 1'b1, 1, 11, 32'h111);
        set_ch(3, 1'b1, 1'b1, 3, 33, 32'h333);
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fix_grant", 32'(f_grant), 1);
            check("fix_x", 32'(f_x), 1);
            check("fix_c", 32'(f_c), 32'h111);
            check("fix_busy", 32'(f_busy), 0);
            check("rr_alt_grant", 32'(grant_id), (i % 2 == 0) ? 1 : 3);
        end
        set_ch(1, 1'b0, 1'b0, 0, 0, 0);
        #1;
        check("fix_ready_ch3", 32'(f_ready), 32'b01000);
        tick();
        check("fix_grant_ch3", 32'(f_grant), 3);
        check("fix_y_ch3", 32'(f_y), 33);
        check("fix_plot", 32'(f_plot), 1);

`ifdef DRAW_ARB_BGADDR_EN
        // Background address registered with the pixel
        clear_all();
        set_ch(0, 1'b1, 1'b1, 319, 239, COL_P0);
        tick();
        check("bg_plot", 32'(plot), 1);
        check("bg_x", 32'(x), 319);
        check("bg_addr", 32'(bg_addr), 76799);
        check("bg_fix_addr", 32'(f_bg), 76799);
        set_ch(0, 1'b1, 1'b0, 5, 2, COL_P0);
        tick();
        check("bg_addr2", 32'(bg_addr), 645);
        check("bg_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check("bg_rst_addr", 32'(bg_addr), 0);
        check("bg_rst_busy", 32'(busy), 0);
        resetn = 1'b1;
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
